// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the load/store port and the memory
// side of the single-port access sequencer.
//   slave  : the arbiter (drives valid/data pulses and the memory address bus)
//   master : the requesters plus the memory model (drive reqs, addresses and read data)
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_valid;
  logic [DW-1:0] f_data;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wEn;
  logic [DW-1:0] mem_outData;
  logic          busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_outData,
    output f_valid, f_data, d_valid, d_rdata, mem_addr, mem_data, mem_wEn, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_outData,
    input  f_valid, f_data, d_valid, d_rdata, mem_addr, mem_data, mem_wEn, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port access sequencer in front of a word memory.
// Arbitrates instruction fetch vs. load/store, registers the memory address,
// write data and write enable for one ACCESS cycle, then returns a one-cycle
// valid pulse in RESP. Sequence IDLE -> ACCESS -> RESP -> IDLE (3 cycles/access).
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (fetch port, data port, memory port, busy)
// Data normally wins a tie; after STARVE_LIMIT consecutive data grants with a
// fetch waiting, fetch is forced through once.
module mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int            CW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          win_d;      // 1 = data port owns the current access
  logic          we_q;       // store flag for the current access
  logic [CW-1:0] starve_cnt;
  logic          pick_d;

  // Data wins unless fetch is waiting and has been starved long enough.
  assign pick_d = bus.d_req & (~bus.f_req | (starve_cnt != LIM));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      win_d       <= 1'b0;
      we_q        <= 1'b0;
      starve_cnt  <= '0;
      bus.f_valid <= 1'b0;
      bus.f_data  <= '0;
      bus.d_valid <= 1'b0;
      bus.d_rdata <= '0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      bus.mem_wEn <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.f_valid <= 1'b0;
      bus.d_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.mem_wEn <= 1'b0;
          if (bus.f_req | bus.d_req) begin
            win_d    <= pick_d;
            bus.busy <= 1'b1;
            state    <= ACCESS;
            if (pick_d) begin
              bus.mem_addr <= bus.d_addr;
              bus.mem_data <= bus.d_wdata;
              we_q         <= bus.d_we;
              bus.mem_wEn  <= bus.d_we;
              // Only count grants that actually made a fetch wait.
              if (bus.f_req)
                starve_cnt <= (starve_cnt == LIM) ? LIM : starve_cnt + 1'b1;
              else
                starve_cnt <= '0;
            end else begin
              bus.mem_addr <= bus.f_addr;
              we_q         <= 1'b0;
              starve_cnt   <= '0;
            end
          end
        end
        ACCESS: begin
          bus.mem_wEn <= 1'b0;
          // Read data is combinational from memory; capture it on the closing edge.
          if (!we_q) begin
            if (win_d) bus.d_rdata <= bus.mem_outData;
            else       bus.f_data  <= bus.mem_outData;
          end
          bus.d_valid <= win_d;
          bus.f_valid <= ~win_d;
          state       <= RESP;
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy    <= 1'b0;
          bus.mem_wEn <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule
